alu_op_sequencer: RTL and testbench

Multi-cycle command sequencer sitting directly upstream and downstream of the combinational 32-bit `alu`. It accepts one register-to-register or register-immediate command at a time from a valid/ready command port. It reads operands from an internal 8x32 register file, drives the ALU's `a`/`b`/`f` inputs from registers, and captures the ALU `result` and flags into the destination register. It returns the outcome on a valid/ready response port.

---
 rtl/alu_op_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: serialises register/immediate commands through an external
// combinational 32-bit ALU. Operands come from an internal 8x32 register file
// (r0 hard-wired to zero); the ALU outcome is written back to rd and returned
// on a valid/ready response port. One command is in flight at a time:
// IDLE (accept) -> EXEC (one cycle, capture) -> RESP (wait for handshake).
module alu_op_sequencer #(
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        reset,
    // command port
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_rs1,
    input  logic [2:0]  cmd_rs2,
    input  logic        cmd_use_imm,
    input  logic [31:0] cmd_imm,
    // ALU connection
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_f,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    input  logic        alu_negative,
    // response port
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    // debug read port
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_SLT   = 3'b101;
    localparam logic [2:0] OP_LOADI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // True for opcodes that are computed by the ALU itself.
    function automatic logic op_is_alu(input logic [2:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: hit = 1'b1;
            default:                               hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_t      state_reg;
    state_t      state_next;

    logic        accept;       // command handshake this cycle
    logic        capture;      // EXEC: latch outcome and write rd
    logic        release_rsp;  // response handshake this cycle

    // Command fields held for the EXEC cycle.
    logic [2:0]  rd_reg;
    logic [2:0]  op_reg;
    logic [31:0] imm_reg;

    // Register file read view; element 0 is a constant zero.
    logic [31:0] rf_q [NREGS];

    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic [2:0]  func_sel;

    logic        op_alu;
    logic        op_loadi;
    logic        op_illegal;
    logic [31:0] cap_result;
    logic [3:0]  cap_flags;
    logic        wr_en;

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid && !reset) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = !reset;
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand selection straight from the command port; the previous command's
    // write landed at least two edges earlier, so no bypass is needed.
    assign opnd_a   = rf_q[cmd_rs1];
    assign opnd_b   = cmd_use_imm ? cmd_imm : rf_q[cmd_rs2];
    assign func_sel = op_is_alu(cmd_op) ? cmd_op : 3'b000;

    // ALU operand registers and latched command fields, loaded on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a   <= 32'd0;
            alu_b   <= 32'd0;
            alu_f   <= 3'b000;
            rd_reg  <= 3'd0;
            op_reg  <= 3'd0;
            imm_reg <= 32'd0;
        end else if (accept) begin
            alu_a   <= opnd_a;
            alu_b   <= opnd_b;
            alu_f   <= func_sel;
            rd_reg  <= cmd_rd;
            op_reg  <= cmd_op;
            imm_reg <= cmd_imm;
        end
    end

    // Outcome of the EXEC cycle, depending on the latched opcode class.
    assign op_alu     = op_is_alu(op_reg);
    assign op_loadi   = (op_reg == OP_LOADI);
    assign op_illegal = !op_alu && !op_loadi;

    always_comb begin
        cap_result = 32'd0;
        cap_flags  = 4'b0000;
        if (op_alu) begin
            cap_result = alu_result;
            cap_flags  = {alu_negative, alu_zero, alu_carry, alu_overflow};
        end else if (op_loadi) begin
            cap_result = imm_reg;
            cap_flags  = {imm_reg[31], (imm_reg == 32'd0), 1'b0, 1'b0};
        end
    end

    assign wr_en = capture && !op_illegal;

    // Response registers: captured in EXEC, frozen through RESP; the error bit
    // is cleared by the response handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result <= 32'd0;
            rsp_flags  <= 4'b0000;
            rsp_err    <= 1'b0;
        end else if (capture) begin
            rsp_result <= cap_result;
            rsp_flags  <= cap_flags;
            rsp_err    <= op_illegal;
        end else if (release_rsp) begin
            rsp_err    <= 1'b0;
        end
    end

    // Register file: r0 is a constant, r1..r(NREGS-1) are individual words.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign rf_q[gi] = 32'd0;
        end else begin : g_word
            logic [31:0] word_q;

            // Write this word when the EXEC cycle targets it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_q <= 32'd0;
                end else if (wr_en && (rd_reg == 3'(gi))) begin
                    word_q <= cap_result;
                end
            end

            assign rf_q[gi] = word_q;
        end
    end

    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a behavioural ALU closes the loop, a
// directed stimulus process issues commands and pushes hand-computed
// responses to a scoreboard, and a monitor pops and compares on each response
// handshake.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic        cmd_use_imm;
    logic [31:0] cmd_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        alu_carry;
    logic        alu_negative;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    alu_op_sequencer #(.NREGS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_use_imm  (cmd_use_imm),
        .cmd_imm      (cmd_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_f        (alu_f),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Behavioural combinational ALU; SUB carry means "no borrow".
    logic [32:0] alu_wide;
    always_comb begin
        alu_wide     = 33'd0;
        alu_overflow = 1'b0;
        case (alu_f)
            3'b000: begin
                alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_wide[31] != alu_a[31]);
            end
            3'b001: begin
                alu_wide     = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_wide[31] != alu_a[31]);
            end
            3'b010:  alu_wide = {1'b0, alu_a & alu_b};
            3'b011:  alu_wide = {1'b0, alu_a | alu_b};
            3'b101:  alu_wide = {32'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_wide = 33'd0;
        endcase
        alu_result   = alu_wide[31:0];
        alu_carry    = alu_wide[32];
        alu_zero     = (alu_wide[31:0] == 32'd0);
        alu_negative = alu_wide[31];
    end

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_regs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a response handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got result 0x%08h, required no response", rsp_result);
            end else begin
                mon_e = sb_q.pop_front();
                $display("rsp: result=0x%08h flags=%b err=%b", rsp_result, rsp_flags, rsp_err);
                check("rsp_result", rsp_result, mon_e.result);
                check("rsp_flags", 32'(rsp_flags), 32'(mon_e.flags));
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    // Issue one command; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic use_imm, input logic [31:0] imm,
                         input logic [31:0] exp_res, input logic [3:0] exp_fl,
                         input logic exp_err, input bit track);
        int waited;
        waited = 0;
        @(negedge clk);
        cmd_op      = op;
        cmd_rd      = rd;
        cmd_rs1     = rs1;
        cmd_rs2     = rs2;
        cmd_use_imm = use_imm;
        cmd_imm     = imm;
        cmd_valid   = 1'b1;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 for 100 cycles, required 1");
            cmd_valid = 1'b0;
            return;
        end
        if (track) begin
            sb_q.push_back(exp_t'{exp_res, exp_fl, exp_err});
            if (!exp_err && rd != 3'd0) exp_regs[rd] = exp_res;
        end
        $display("cmd: op=%b rd=%0d rs1=%0d rs2=%0d use_imm=%b imm=0x%08h", op, rd, rs1, rs2, use_imm, imm);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for all expected responses to be consumed, bounded.
    task automatic drain();
        int waited;
        waited = 0;
        while ((sb_q.size() != 0 || rsp_valid) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0 || rsp_valid) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", sb_q.size());
        end
    endtask

    task automatic check_reg(input logic [2:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        check($sformatf("dbg_r%0d", idx), dbg_data, exp);
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 3'd0;
        cmd_rd      = 3'd0;
        cmd_rs1     = 3'd0;
        cmd_rs2     = 3'd0;
        cmd_use_imm = 1'b0;
        cmd_imm     = 32'd0;
        rsp_ready   = 1'b1;
        dbg_addr    = 3'd0;
        for (int i = 0; i < 8; i++) exp_regs[i] = 32'd0;

        // Reset for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check("cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) check_reg(3'(i), 32'd0);
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
        check("rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
        check("alu_f_after_reset", 32'(alu_f), 32'd0);

        // Overflow add
        issue(3'b111, 3'd1, 3'd0, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0000, 1'b0, 1'b1);
        issue(3'b111, 3'd2, 3'd0, 3'd0, 1'b0, 32'h0000_0001, 32'h0000_0001, 4'b0000, 1'b0, 1'b1);
        drain();
        issue(3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, 32'h8000_0000, 4'b1001, 1'b0, 1'b1);
        check("add_alu_a", alu_a, 32'h7FFF_FFFF);
        check("add_alu_b", alu_b, 32'h0000_0001);
        check("add_alu_f", 32'(alu_f), 32'd0);
        check("add_rsp_valid_n", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("add_rsp_valid_n1", 32'(rsp_valid), 32'd1);
        drain();
        check_reg(3'd3, 32'h8000_0000);

        // SUB to zero, then SLT with immediate
        issue(3'b001, 3'd4, 3'd2, 3'd2, 1'b0, 32'd0, 32'h0000_0000, 4'b0110, 1'b0, 1'b1);
        issue(3'b111, 3'd5, 3'd0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b1);
        issue(3'b101, 3'd6, 3'd5, 3'd0, 1'b1, 32'd0, 32'h0000_0001, 4'b0000, 1'b0, 1'b1);
        check("slt_alu_f", 32'(alu_f), 32'd5);
        check("slt_alu_b_imm", alu_b, 32'd0);
        drain();
        check_reg(3'd4, 32'h0000_0000);
        check_reg(3'd6, 32'h0000_0001);

        // Backpressure with a competing command held on the port
        rsp_ready = 1'b0;
        issue(3'b011, 3'd7, 3'd1, 3'd2, 1'b0, 32'd0, 32'h7FFF_FFFF, 4'b0000, 1'b0, 1'b1);
        cmd_op      = 3'b111;
        cmd_rd      = 3'd7;
        cmd_use_imm = 1'b0;
        cmd_imm     = 32'd0;
        cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", rsp_result, 32'h7FFF_FFFF);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check_reg(3'd7, 32'h7FFF_FFFF);
        rsp_ready = 1'b1;
        issue(3'b111, 3'd7, 3'd0, 3'd0, 1'b0, 32'd0, 32'h0000_0000, 4'b0100, 1'b0, 1'b1);
        drain();
        check_reg(3'd7, 32'h0000_0000);

        // Write to r0 is discarded
        issue(3'b000, 3'd0, 3'd1, 3'd2, 1'b0, 32'd0, 32'h8000_0000, 4'b1001, 1'b0, 1'b1);
        drain();
        check_reg(3'd0, 32'h0000_0000);

        // Illegal opcode leaves every register unchanged
        issue(3'b100, 3'd1, 3'd1, 3'd2, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 4'b0000, 1'b1, 1'b1);
        check("illegal_alu_f", 32'(alu_f), 32'd0);
        drain();
        for (int i = 0; i < 8; i++) check_reg(3'(i), exp_regs[i]);

        // Reset during EXEC abandons the LOADI
        issue(3'b111, 3'd3, 3'd0, 3'd0, 1'b0, 32'h1234_5678, 32'd0, 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midop_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midop_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_reg(3'd3, 32'h0000_0000);
        check_reg(3'd1, 32'h0000_0000);
        check("midop_alu_a", alu_a, 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
